// File: rtl/i2s_sample_rx.sv
// i2s_sample_rx: oversampling I2S receiver producing paired 24-bit L/R samples
module i2s_sample_rx #(
  parameter int DATA_BITS     = 24,
  parameter int SLOT_BITS     = 32,
  parameter int OFFSET_BINARY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bclk,
  input  logic                 lrclk,
  input  logic                 sdata,
  output logic [DATA_BITS-1:0] sample_l,
  output logic [DATA_BITS-1:0] sample_r,
  output logic                 sample_valid,
  output logic                 frame_err
);
  localparam int CW = $clog2(SLOT_BITS + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] SMAX = CW'(SLOT_BITS);
  localparam logic [DATA_BITS-1:0] OBM = {OFFSET_BINARY != 0, {(DATA_BITS-1){1'b0}}};
  localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, PAD = 2'd2;
  logic [1:0] b_sync_q, l_sync_q, d_sync_q;
  logic b_prev_q, rise_q, lr_q, sd_q;
  logic [1:0] state_q, state_d;
  logic ch_q, ch_d, lrp_q, lrp_d, left_ok_q, left_ok_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d, slot_cnt_q, slot_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, hold_q, hold_d;
  logic upd_q, upd_d, err_q, err_d;
  logic [DATA_BITS-1:0] sample_l_q, sample_r_q;
  logic valid_q, ferr_q;
  logic edge_w;
  // Sync plus one registered event stage keeps the edge-to-valid latency at four clks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_sync_q <= '0;
      l_sync_q <= '0;
      d_sync_q <= '0;
      b_prev_q <= 1'b0;
      rise_q   <= 1'b0;
      lr_q     <= 1'b0;
      sd_q     <= 1'b0;
    end else begin
      b_sync_q <= {b_sync_q[0], bclk};
      l_sync_q <= {l_sync_q[0], lrclk};
      d_sync_q <= {d_sync_q[0], sdata};
      b_prev_q <= b_sync_q[1];
      rise_q   <= b_sync_q[1] & ~b_prev_q;
      lr_q     <= l_sync_q[1];
      sd_q     <= d_sync_q[1];
    end
  end
  assign edge_w = rise_q && (lr_q != lrp_q);
  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    lrp_d      = lrp_q;
    left_ok_d  = left_ok_q;
    bit_cnt_d  = bit_cnt_q;
    slot_cnt_d = slot_cnt_q;
    shift_d    = shift_q;
    hold_d     = hold_q;
    upd_d      = 1'b0;
    err_d      = 1'b0;
    if (rise_q) begin
      lrp_d = lr_q;
      if (edge_w) begin
        slot_cnt_d = '0;
        bit_cnt_d  = '0;
        ch_d       = lr_q;
        state_d    = SHIFT;
        err_d      = (state_q == SHIFT);
        left_ok_d  = left_ok_q && state_q != SHIFT && lr_q;
      end else begin
        slot_cnt_d = (slot_cnt_q == SMAX) ? slot_cnt_q : slot_cnt_q + 1'b1;
        if (state_q != IDLE && slot_cnt_q == SMAX) begin
          err_d     = 1'b1;
          state_d   = IDLE;
          left_ok_d = 1'b0;
        end else if (state_q == SHIFT) begin
          shift_d   = {shift_q[DATA_BITS-2:0], sd_q};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST) begin
            state_d   = PAD;
            hold_d    = ch_q ? hold_q : shift_d;
            upd_d     = ch_q && left_ok_q;
            left_ok_d = !ch_q;
          end
        end
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ch_q       <= 1'b0;
      lrp_q      <= 1'b0;
      left_ok_q  <= 1'b0;
      bit_cnt_q  <= '0;
      slot_cnt_q <= '0;
      shift_q    <= '0;
      hold_q     <= '0;
      upd_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      lrp_q      <= lrp_d;
      left_ok_q  <= left_ok_d;
      bit_cnt_q  <= bit_cnt_d;
      slot_cnt_q <= slot_cnt_d;
      shift_q    <= shift_d;
      hold_q     <= hold_d;
      upd_q      <= upd_d;
      err_q      <= err_d;
    end
  end
  // The right word stays in shift_q while in PAD, so it is still intact here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_l_q <= '0;
      sample_r_q <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      valid_q <= upd_q;
      ferr_q  <= err_q;
      if (upd_q) begin
        sample_l_q <= hold_q ^ OBM;
        sample_r_q <= shift_q ^ OBM;
      end
    end
  end
  assign sample_l     = sample_l_q;
  assign sample_r     = sample_r_q;
  assign sample_valid = valid_q;
  assign frame_err    = ferr_q;
endmodule

// File: tb/tb_i2s_sample_rx.sv
// tb_i2s_sample_rx: directed vectors and corner sequences for i2s_sample_rx
module tb_i2s_sample_rx;
  logic clk = 1'b0, rst = 1'b1, bclk = 1'b0, lrclk = 1'b0, sdata = 1'b0;
  logic [23:0] l0, r0, l1, r1;
  logic v0, e0, v1, e1;
  int n_assert = 0, n_fail = 0;
  int cyc = 0, nv0 = 0, ne0 = 0, viol = 0;
  int vt[$];
  logic [23:0] pl = '0, pr = '0;
  logic pv = 1'b0, pe = 1'b0;

  i2s_sample_rx #(.DATA_BITS(24), .SLOT_BITS(32), .OFFSET_BINARY(0)) dut0 (
    .clk(clk), .rst(rst), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
    .sample_l(l0), .sample_r(r0), .sample_valid(v0), .frame_err(e0));
  i2s_sample_rx #(.DATA_BITS(24), .SLOT_BITS(32), .OFFSET_BINARY(1)) dut1 (
    .clk(clk), .rst(rst), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
    .sample_l(l1), .sample_r(r1), .sample_valid(v1), .frame_err(e1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (v0) begin
      nv0 <= nv0 + 1;
      vt.push_back(cyc);
    end
    if (e0) ne0 <= ne0 + 1;
    if (!rst && !v0 && (l0 != pl || r0 != pr)) viol <= viol + 1;
    if ((v0 && pv) || (e0 && pe) || (v0 && e0)) viol <= viol + 1;
    pl <= l0;
    pr <= r0;
    pv <= v0;
    pe <= e0;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bclk_cyc(input logic lr, input logic sd);
    bclk = 1'b0;
    lrclk = lr;
    sdata = sd;
    repeat (4) @(negedge clk);
    bclk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Bit 0 of a slot carries the LRCLK transition and is not data
  task automatic send_slot(input logic ch, input logic [23:0] w, input int n);
    for (int i = 0; i < n; i++)
      bclk_cyc(ch, (i >= 1 && i <= 24) ? w[24-i] : 1'b0);
  endtask

  task automatic send_frame(input logic [23:0] l, input logic [23:0] r);
    send_slot(1'b0, l, 32);
    send_slot(1'b1, r, 32);
  endtask

  typedef struct {
    logic [23:0] l, r, el0, er0, el1, er1;
  } vec_t;
  vec_t vecs[5];

  initial begin
    int bv, be, bq;
    vecs[0] = '{24'h123456, 24'hABCDEF, 24'h123456, 24'hABCDEF, 24'h923456, 24'h2BCDEF};
    vecs[1] = '{24'h800000, 24'h7FFFFF, 24'h800000, 24'h7FFFFF, 24'h000000, 24'hFFFFFF};
    vecs[2] = '{24'h000000, 24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'h800000, 24'h7FFFFF};
    vecs[3] = '{24'h000001, 24'h000002, 24'h000001, 24'h000002, 24'h800001, 24'h800002};
    vecs[4] = '{24'h5A5A5A, 24'hA5A5A5, 24'h5A5A5A, 24'hA5A5A5, 24'hDA5A5A, 24'h25A5A5};
    repeat (3) @(negedge clk);
    chk("reset_l", 32'(l0), 32'h0);
    chk("reset_r", 32'(r0), 32'h0);
    chk("reset_valid", 32'(v0), 32'h0);
    chk("reset_err", 32'(e0), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    send_slot(1'b1, 24'h0, 32);
    chk("preamble_no_valid", 32'(nv0), 32'd0);
    chk("preamble_no_err", 32'(ne0), 32'd0);

    for (int k = 0; k < 5; k++) begin
      bv = nv0;
      be = ne0;
      send_frame(vecs[k].l, vecs[k].r);
      chk($sformatf("vec%0d_valid_cnt", k), 32'(nv0 - bv), 32'd1);
      chk($sformatf("vec%0d_err_cnt", k), 32'(ne0 - be), 32'd0);
      chk($sformatf("vec%0d_l_ob0", k), 32'(l0), 32'(vecs[k].el0));
      chk($sformatf("vec%0d_r_ob0", k), 32'(r0), 32'(vecs[k].er0));
      chk($sformatf("vec%0d_l_ob1", k), 32'(l1), 32'(vecs[k].el1));
      chk($sformatf("vec%0d_r_ob1", k), 32'(r1), 32'(vecs[k].er1));
    end

    bq = vt.size();
    be = ne0;
    for (int k = 0; k < 3; k++) send_frame(24'h0F0F0F + 24'(k), 24'hF0F0F0 - 24'(k));
    chk("b2b_valid_cnt", 32'(vt.size() - bq), 32'd3);
    chk("b2b_err_cnt", 32'(ne0 - be), 32'd0);
    if (vt.size() - bq == 3) begin
      chk("b2b_gap1", 32'(vt[bq+1] - vt[bq]), 32'd512);
      chk("b2b_gap2", 32'(vt[bq+2] - vt[bq+1]), 32'd512);
    end
    chk("b2b_last_l", 32'(l0), 32'h0F0F11);
    chk("b2b_last_r", 32'(r0), 32'hF0F0EE);

    bv = nv0;
    be = ne0;
    send_slot(1'b0, 24'hFFFFFF, 11);
    send_slot(1'b1, 24'h000000, 32);
    chk("short_err_cnt", 32'(ne0 - be), 32'd1);
    chk("short_no_valid", 32'(nv0 - bv), 32'd0);
    send_frame(24'h000001, 24'h000002);
    chk("short_recover_valid", 32'(nv0 - bv), 32'd1);
    chk("short_recover_err", 32'(ne0 - be), 32'd1);
    chk("short_recover_l", 32'(l0), 32'h000001);
    chk("short_recover_r", 32'(r0), 32'h000002);

    send_frame(24'h111111, 24'h222222);
    bv = nv0;
    be = ne0;
    send_slot(1'b0, 24'h333333, 33);
    chk("ovf_none_at_32", 32'(ne0 - be), 32'd0);
    send_slot(1'b0, 24'h0, 2);
    chk("ovf_err_at_33", 32'(ne0 - be), 32'd1);
    send_slot(1'b0, 24'h0, 5);
    chk("ovf_single_pulse", 32'(ne0 - be), 32'd1);
    chk("ovf_hold_l", 32'(l0), 32'h111111);
    send_slot(1'b1, 24'h0, 32);
    chk("ovf_idle_no_valid", 32'(nv0 - bv), 32'd0);
    send_frame(24'h0ABCDE, 24'h0FEDCB);
    chk("ovf_recover_valid", 32'(nv0 - bv), 32'd1);
    chk("ovf_recover_l", 32'(l0), 32'h0ABCDE);
    chk("ovf_recover_r", 32'(r0), 32'h0FEDCB);

    send_slot(1'b0, 24'h444444, 32);
    send_slot(1'b1, 24'h555555, 10);
    rst = 1'b1;
    #1;
    chk("async_rst_l", 32'(l0), 32'h0);
    chk("async_rst_r", 32'(r0), 32'h0);
    chk("async_rst_l_ob1", 32'(l1), 32'h0);
    chk("async_rst_valid", 32'(v0), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bv = nv0;
    send_slot(1'b1, 24'h555555, 22);
    chk("post_rst_no_valid", 32'(nv0 - bv), 32'd0);
    chk("post_rst_l_zero", 32'(l0), 32'h0);
    send_frame(24'h600001, 24'h700002);
    chk("post_rst_valid", 32'(nv0 - bv), 32'd1);
    chk("post_rst_l", 32'(l0), 32'h600001);
    chk("post_rst_r", 32'(r0), 32'h700002);
    chk("post_rst_l_ob1", 32'(l1), 32'hE00001);

    chk("stability_pulse_violations", 32'(viol), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
